// File: rtl/uart_regs_arbiter_if.sv
// Bus bundle between the two cores, the arbiter and the UART register bank.
//   a_*/b_*  : per-core request channel (req/we/addr/wdata in, ack/err/rdata out)
//   reg_*    : single register-bank port (addr/we/re/wdata out, rdata in)
//   busy     : arbiter has an access in flight
// slave  = arbiter side, master = cores + register bank side.
interface uart_regs_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [21:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic        a_err;
  logic [31:0] a_rdata;

  logic        b_req;
  logic        b_we;
  logic [21:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic        b_err;
  logic [31:0] b_rdata;

  logic [21:0] reg_addr;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  logic        busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_err, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_err, b_rdata,
    output reg_addr, reg_we, reg_re, reg_wdata,
    input  reg_rdata,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_err, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_err, b_rdata,
    input  reg_addr, reg_we, reg_re, reg_wdata,
    output reg_rdata,
    input  busy
  );
endinterface

// File: rtl/uart_regs_arbiter.sv
// Two-master arbiter for the 4-channel UART register bank.
// Serialises core A / core B accesses (round robin on contention), checks
// per-core channel ownership and issues exactly one single-cycle reg_we or
// reg_re per legal access, since TDR writes and SR/RDR reads have side effects.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : uart_regs_arbiter_if.slave (core channels, register port, busy)
// Sequence per access: IDLE (grant + latch) -> ISSUE (strobe) -> RESP (ack).
module uart_regs_arbiter #(
  parameter logic [3:0]  A_CH_MASK = 4'b0011,
  parameter logic [3:0]  B_CH_MASK = 4'b1100,
  parameter logic [21:0] ADDR_MAX  = 22'h0f
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_regs_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e      state_q;
  logic        last_b_q;     // 1: core B held the last grant
  logic        gnt_b_q;      // core owning the access in flight
  logic        we_q;
  logic        illegal_q;
  logic        busy_q;

  // The reg_* registers double as the address/data latches of the granted
  // access; they are only non-zero while in ISSUE.
  logic [21:0] reg_addr_q;
  logic [31:0] reg_wdata_q;
  logic        reg_we_q;
  logic        reg_re_q;

  logic        a_ack_q, a_err_q;
  logic        b_ack_q, b_err_q;
  logic [31:0] a_rdata_q, b_rdata_q;

  // Grant selection and legality of the candidate request.
  logic        any_req;
  logic        pick_b;
  logic        sel_we;
  logic [21:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_mask;
  logic        sel_legal;

  always_comb begin
    any_req   = bus.a_req | bus.b_req;
    // B wins only when A is idle or when A was granted last.
    pick_b    = bus.b_req & (~bus.a_req | ~last_b_q);
    sel_we    = pick_b ? bus.b_we    : bus.a_we;
    sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
    sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
    sel_mask  = pick_b ? B_CH_MASK   : A_CH_MASK;
    sel_legal = (sel_addr <= ADDR_MAX) & sel_mask[sel_addr[3:2]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_b_q    <= 1'b1;   // A wins the first tie
      gnt_b_q     <= 1'b0;
      we_q        <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      a_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      // Strobes, bank address and acks are single-cycle by construction.
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      a_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      b_err_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            gnt_b_q   <= pick_b;
            last_b_q  <= pick_b;
            we_q      <= sel_we;
            illegal_q <= ~sel_legal;
            busy_q    <= 1'b1;
            // Illegal accesses never reach the bank: no strobe, address 0.
            if (sel_legal) begin
              reg_we_q    <= sel_we;
              reg_re_q    <= ~sel_we;
              reg_addr_q  <= sel_addr;
              reg_wdata_q <= sel_wdata;
            end
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Capture read data now so it is already valid alongside the ack.
          if (!we_q) begin
            if (gnt_b_q) b_rdata_q <= illegal_q ? 32'd0 : bus.reg_rdata;
            else         a_rdata_q <= illegal_q ? 32'd0 : bus.reg_rdata;
          end
          if (gnt_b_q) begin
            b_ack_q <= 1'b1;
            b_err_q <= illegal_q;
          end else begin
            a_ack_q <= 1'b1;
            a_err_q <= illegal_q;
          end
          state_q <= S_RESP;
        end

        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_re    = reg_re_q;
  assign bus.a_ack     = a_ack_q;
  assign bus.a_err     = a_err_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.b_err     = b_err_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_regs_arbiter.sv
// Directed bench for uart_regs_arbiter: single-core write/read, round robin,
// ownership errors, reset during ISSUE and a randomised strobe-count run.
module tb_uart_regs_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_regs_arbiter_if bus ();

  uart_regs_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Strobe monitor, sampling on the falling edge.
  int          n_we = 0;
  int          n_re = 0;
  logic [21:0] s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic        mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.reg_we) begin
        n_we++;
        s_addr  = bus.reg_addr;
        s_wdata = bus.reg_wdata;
      end
      if (bus.reg_re) begin
        n_re++;
        s_addr = bus.reg_addr;
      end
      total++;
      if (bus.reg_we && bus.reg_re) begin
        bad++;
        $display("FAIL strobe_excl: we=%b re=%b, required not both high", bus.reg_we, bus.reg_re);
      end
      total++;
      if (!bus.reg_we && !bus.reg_re && bus.reg_addr !== 22'd0) begin
        bad++;
        $display("FAIL idle_addr: reg_addr=%h without strobe, required 0", bus.reg_addr);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Falling edge plus 1: drive/sample point, clear of the monitor and the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [124:0] outs();
    return {bus.a_ack, bus.a_err, bus.b_ack, bus.b_err, bus.reg_we, bus.reg_re, bus.busy,
            bus.reg_addr, bus.reg_wdata, bus.a_rdata, bus.b_rdata};
  endfunction

  // Drives one access from a single core and waits (bounded) for its ack.
  task automatic run_one(input bit core_b, input bit we, input logic [21:0] addr,
                         input logic [31:0] wdata, output int cyc, output bit got,
                         output bit err, output logic [31:0] rd);
    cyc = 0; got = 0; err = 0; rd = '0;
    tick();
    if (core_b) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (core_b ? bus.b_ack : bus.a_ack) begin
        cyc = i; got = 1'b1;
        err = core_b ? bus.b_err : bus.a_err;
        rd  = core_b ? bus.b_rdata : bus.a_rdata;
        break;
      end
    end
    if (core_b) bus.b_req = 1'b0;
    else        bus.a_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.reg_rdata = '0;
    tick(); tick();
    total++;
    if (outs() !== '0) begin
      bad++; $display("FAIL reset_outs: got %h, required 0", outs());
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();
    total++;
    if (outs() !== '0) begin
      bad++; $display("FAIL reset_idle: got %h, required 0", outs());
    end
  endtask

  task automatic test_a_write();
    int cyc; bit got, err; logic [31:0] rd;
    n_we = 0; n_re = 0;
    run_one(1'b0, 1'b1, 22'h02, 32'h55, cyc, got, err, rd);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL aw_ack: got=%b, required 1", got); end
    total++; if (cyc != 2) begin bad++; $display("FAIL aw_latency: ack in cycle %0d, required 2", cyc); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL aw_err: got %b, required 0", err); end
    total++; if (n_we != 1 || n_re != 0) begin bad++; $display("FAIL aw_strobes: we=%0d re=%0d, required 1/0", n_we, n_re); end
    total++; if (s_addr !== 22'h02 || s_wdata !== 32'h55) begin
      bad++; $display("FAIL aw_bus: addr=%h wdata=%h, required 2/55", s_addr, s_wdata);
    end
    tick();
    total++; if (bus.a_ack !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL aw_single: ack=%b busy=%b, required 0/0", bus.a_ack, bus.busy);
    end
  endtask

  task automatic test_b_read();
    int cyc; bit got, err; logic [31:0] rd;
    n_we = 0; n_re = 0;
    bus.reg_rdata = 32'h1234abcd;
    run_one(1'b1, 1'b0, 22'h0b, 32'h0, cyc, got, err, rd);
    total++; if (got !== 1'b1 || cyc != 2) begin bad++; $display("FAIL br_ack: got=%b cyc=%0d, required 1/2", got, cyc); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL br_err: got %b, required 0", err); end
    total++; if (rd !== 32'h1234abcd) begin bad++; $display("FAIL br_rdata: got %h, required 1234abcd", rd); end
    total++; if (n_re != 1 || n_we != 0 || s_addr !== 22'h0b) begin
      bad++; $display("FAIL br_strobes: re=%0d we=%0d addr=%h, required 1/0/0b", n_re, n_we, s_addr);
    end
  endtask

  task automatic test_round_robin();
    for (int r = 0; r < 2; r++) begin
      int a_cyc = 0, b_cyc = 0;
      n_we = 0; n_re = 0;
      tick();
      bus.a_req = 1; bus.a_we = 1; bus.a_addr = 22'h00; bus.a_wdata = 32'(r);
      bus.b_req = 1; bus.b_we = 1; bus.b_addr = 22'h08; bus.b_wdata = 32'(r + 16);
      for (int i = 1; i <= 15; i++) begin
        tick();
        if (bus.a_req && bus.a_ack) begin a_cyc = i; bus.a_req = 0; end
        if (bus.b_req && bus.b_ack) begin b_cyc = i; bus.b_req = 0; end
        if (!bus.a_req && !bus.b_req) break;
      end
      bus.a_req = 0; bus.b_req = 0;
      total++; if (a_cyc != 2) begin bad++; $display("FAIL rr%0d_a: a ack cycle %0d, required 2", r, a_cyc); end
      total++; if (b_cyc != 5) begin bad++; $display("FAIL rr%0d_b: b ack cycle %0d, required 5", r, b_cyc); end
      total++; if (n_we != 2) begin bad++; $display("FAIL rr%0d_we: %0d write strobes, required 2", r, n_we); end
    end
  endtask

  task automatic test_ownership();
    int cyc; bit got, err; logic [31:0] rd;
    bus.reg_rdata = 32'hdeadbeef;
    run_one(1'b0, 1'b0, 22'h05, 32'h0, cyc, got, err, rd);
    total++; if (got !== 1'b1 || err !== 1'b0 || rd !== 32'hdeadbeef) begin
      bad++; $display("FAIL own_legal_rd: got=%b err=%b rdata=%h, required 1/0/deadbeef", got, err, rd);
    end
    n_we = 0; n_re = 0;
    run_one(1'b0, 1'b1, 22'h0c, 32'hffffffff, cyc, got, err, rd);
    total++; if (got !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL own_wr_err: got=%b err=%b, required 1/1", got, err); end
    total++; if (n_we != 0) begin bad++; $display("FAIL own_wr_strobe: %0d write strobes, required 0", n_we); end
    total++; if (rd !== 32'hdeadbeef) begin bad++; $display("FAIL own_wr_keep: rdata=%h, required deadbeef", rd); end
    n_we = 0; n_re = 0;
    run_one(1'b0, 1'b0, 22'h10, 32'h0, cyc, got, err, rd);
    total++; if (got !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL own_rd_err: got=%b err=%b, required 1/1", got, err); end
    total++; if (rd !== 32'h0 || n_re != 0) begin bad++; $display("FAIL own_rd_zero: rdata=%h re=%0d, required 0/0", rd, n_re); end
    run_one(1'b1, 1'b1, 22'h01, 32'h7, cyc, got, err, rd);
    total++; if (got !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL own_b_err: got=%b err=%b, required 1/1", got, err); end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    bus.reg_rdata = 32'hcafe0001;
    tick();
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 22'h01;
    tick();
    total++; if (bus.reg_re !== 1'b1) begin bad++; $display("FAIL rst_pre: reg_re=%b in ISSUE, required 1", bus.reg_re); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.reg_re !== 1'b0 || bus.busy !== 1'b0 || bus.reg_addr !== 22'd0) begin
      bad++; $display("FAIL rst_async: re=%b busy=%b addr=%h, required 0/0/0", bus.reg_re, bus.busy, bus.reg_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.a_ack) acks++;
    end
    bus.a_req = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.a_ack) acks++;
    end
    total++; if (acks != 0) begin bad++; $display("FAIL rst_noack: %0d acks, required 0", acks); end
    total++; if (outs() !== '0) begin bad++; $display("FAIL rst_after: outs=%h, required 0", outs()); end
  endtask

  task automatic test_random();
    logic [3:0]  amask = 4'b0011;
    logic [3:0]  bmask = 4'b1100;
    logic [31:0] am = '0, bm = '0;
    int exp_legal = 0, legal_acks = 0;
    n_we = 0; n_re = 0;
    for (int t = 0; t < 100; t++) begin
      int mode = int'($urandom_range(1, 3));
      bit wa = mode[0], wb = mode[1], ad = 0, bd = 0;
      bit la, lb;
      logic [31:0] pat = $urandom;
      logic [21:0] aa = 22'($urandom_range(0, 19));
      logic [21:0] ba = 22'($urandom_range(0, 19));
      bit awe = 1'($urandom_range(0, 1));
      bit bwe = 1'($urandom_range(0, 1));
      la = (aa <= 22'h0f) && amask[aa[3:2]];
      lb = (ba <= 22'h0f) && bmask[ba[3:2]];
      if (wa && la) exp_legal++;
      if (wb && lb) exp_legal++;
      tick();
      bus.reg_rdata = pat;
      if (wa) begin bus.a_req = 1; bus.a_we = awe; bus.a_addr = aa; bus.a_wdata = $urandom; end
      if (wb) begin bus.b_req = 1; bus.b_we = bwe; bus.b_addr = ba; bus.b_wdata = $urandom; end
      for (int i = 0; i < 20; i++) begin
        tick();
        if (wa && !ad && bus.a_ack) begin
          ad = 1; bus.a_req = 0;
          if (!awe) am = la ? pat : 32'h0;
          if (!bus.a_err) legal_acks++;
          total++;
          if (bus.a_err !== !la || bus.a_rdata !== am) begin
            bad++; $display("FAIL rnd%0d_a: err=%b rdata=%h, required %b/%h", t, bus.a_err, bus.a_rdata, !la, am);
          end
        end
        if (wb && !bd && bus.b_ack) begin
          bd = 1; bus.b_req = 0;
          if (!bwe) bm = lb ? pat : 32'h0;
          if (!bus.b_err) legal_acks++;
          total++;
          if (bus.b_err !== !lb || bus.b_rdata !== bm) begin
            bad++; $display("FAIL rnd%0d_b: err=%b rdata=%h, required %b/%h", t, bus.b_err, bus.b_rdata, !lb, bm);
          end
        end
        if ((!wa || ad) && (!wb || bd)) break;
      end
      total++;
      if ((wa && !ad) || (wb && !bd)) begin
        bad++; $display("FAIL rnd%0d_timeout: a_done=%b b_done=%b, required all done", t, ad, bd);
        bus.a_req = 0; bus.b_req = 0;
      end
    end
    tick();
    total++; if (n_we + n_re != exp_legal) begin
      bad++; $display("FAIL rnd_strobes: %0d strobes, required %0d", n_we + n_re, exp_legal);
    end
    total++; if (legal_acks != exp_legal) begin
      bad++; $display("FAIL rnd_legal_acks: %0d, required %0d", legal_acks, exp_legal);
    end
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_b_read();
    test_round_robin();
    test_ownership();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
